// File: rtl/fix_ram_pkg.sv
// Shared types for the message-buffer RAM port arbiter: FSM state, the
// registered RAM command and a wrap-around increment for the priority pointer.
package fix_ram_pkg;

  localparam int MAX_REQ        = 8;
  localparam int ID_WIDTH       = $clog2(MAX_REQ);
  // Command fields are sized for the widest port this block may drive.
  localparam int MAX_ADDR_WIDTH = 32;
  localparam int MAX_DATA_WIDTH = 64;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                      we;
    logic [MAX_ADDR_WIDTH-1:0] addr;
    logic [MAX_DATA_WIDTH-1:0] wdata;
    logic [ID_WIDTH-1:0]       id;
  } ram_cmd_t;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping modulo NUM_REQ. Returns a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM port between NUM_REQ requesters with round-robin
// arbitration, a burst lock, a registered command stage and read-data return.
module ram_port_arbiter
  import fix_ram_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0]                   req_lock,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_rdata,
  output logic                                 ram_cs,
  output logic                                 ram_we,
  output logic                                 ram_oe,
  output logic [ADDR_WIDTH-1:0]                ram_address,
  output logic [DATA_WIDTH-1:0]                ram_wdata,
  input  logic [DATA_WIDTH-1:0]                ram_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t                  state_q, state_d;
  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic [IDX_W-1:0]            owner_q, owner_d;
  ram_cmd_t                    cmd_q, cmd_d;
  logic                        cs_q, cs_d;
  logic                        we_q, we_d;
  logic                        oe_q, oe_d;
  logic [1:0]                  tag_valid_q, tag_valid_d;
  logic [1:0][IDX_W-1:0]       tag_id_q, tag_id_d;

  logic [NUM_REQ-1:0]          owner_mask;
  logic [NUM_REQ-1:0]          arb_req;
  logic [NUM_REQ-1:0]          grant;
  logic [IDX_W-1:0]            grant_idx;
  logic                        xfer;
  logic                        unused_cmd_bits;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_per_req
      assign owner_mask[gi] = (owner_q == IDX_W'(gi));
      assign rsp_valid[gi]  = !rst && tag_valid_q[1] && (tag_id_q[1] == IDX_W'(gi));
    end
  endgenerate

  // While locked only the owner competes, so an idle owner stalls everyone.
  assign arb_req = (state_q == LOCK) ? (req_valid & owner_mask) : req_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (arb_req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = rst ? '0 : grant;
  assign xfer      = |grant;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cmd_d       = cmd_q;
    cs_d        = xfer;
    we_d        = xfer && req_we[grant_idx];
    oe_d        = xfer && !req_we[grant_idx];
    tag_valid_d = {tag_valid_q[0], oe_d};
    tag_id_d    = {tag_id_q[0], grant_idx};

    case (state_q)
      ARB: begin
        if (xfer) begin
          ptr_d = IDX_W'(wrap_inc(32'(grant_idx), 32'(NUM_REQ)));
          if (req_lock[grant_idx]) begin
            state_d = LOCK;
            owner_d = grant_idx;
          end
        end
      end
      LOCK: begin
        if (xfer && !req_lock[grant_idx]) begin
          state_d = ARB;
          ptr_d   = IDX_W'(wrap_inc(32'(owner_q), 32'(NUM_REQ)));
        end
      end
      default: state_d = ARB;
    endcase

    // Address and data hold their last value between commands.
    if (xfer) begin
      cmd_d.we    = req_we[grant_idx];
      cmd_d.addr  = MAX_ADDR_WIDTH'(req_addr[grant_idx]);
      cmd_d.wdata = req_we[grant_idx] ? MAX_DATA_WIDTH'(req_wdata[grant_idx]) : '0;
      cmd_d.id    = ID_WIDTH'(grant_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      cmd_q       <= '0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      tag_valid_q <= '0;
      tag_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cmd_q       <= cmd_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
    end
  end

  assign ram_cs      = cs_q;
  assign ram_we      = we_q;
  assign ram_oe      = oe_q;
  assign ram_address = cmd_q.addr[ADDR_WIDTH-1:0];
  assign ram_wdata   = cmd_q.wdata[DATA_WIDTH-1:0];
  assign rsp_rdata   = (!rst && tag_valid_q[1]) ? ram_rdata : '0;

  // Upper command bits are zero-extension; we/id travel via their own flops.
  assign unused_cmd_bits = ^{cmd_q.we, cmd_q.id, cmd_q.addr, cmd_q.wdata};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, shadow memory and scoreboard
// queues for expected RAM commands and read responses.
module tb_ram_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NR-1:0]          req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0][DW-1:0]  req_wdata;
  logic [DW-1:0]          rsp_rdata, ram_wdata, ram_rdata;
  logic                   ram_cs, ram_we, ram_oe;
  logic [AW-1:0]          ram_address;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] mem    [256];
  logic [DW-1:0] shadow [256];

  typedef struct { int due; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } cmd_exp_t;
  typedef struct { int due; logic [NR-1:0] id1h; logic [DW-1:0] data; } rsp_exp_t;
  cmd_exp_t cmd_sb[$];
  rsp_exp_t rsp_sb[$];

  int rr_seq [5] = '{0, 1, 2, 3, 0};

  ram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .ram_cs      (ram_cs),
    .ram_we      (ram_we),
    .ram_oe      (ram_oe),
    .ram_address (ram_address),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: write in the command cycle, registered read data.
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_address] <= ram_wdata;
    ram_rdata <= (ram_cs && ram_oe) ? mem[ram_address] : '0;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Scoreboard monitor: checks due commands/responses, then records transfers.
  always @(negedge clk) begin
    cmd_exp_t c;
    rsp_exp_t r;
    logic [NR-1:0] xf;
    int idx;
    if (rst) begin
      cmd_sb.delete();
      rsp_sb.delete();
    end else begin
      if (cmd_sb.size() > 0 && cmd_sb[0].due == cyc) begin
        c = cmd_sb.pop_front();
        check_eq("ram_cs", 64'(ram_cs), 64'd1);
        check_eq("ram_we", 64'(ram_we), 64'(c.we));
        check_eq("ram_oe", 64'(ram_oe), 64'(!c.we));
        check_eq("ram_address", 64'(ram_address), 64'(c.addr));
        check_eq("ram_wdata", 64'(ram_wdata), 64'(c.wdata));
      end else begin
        check_eq("ram_cs_idle", 64'(ram_cs), 64'd0);
      end
      if (rsp_sb.size() > 0 && rsp_sb[0].due == cyc) begin
        r = rsp_sb.pop_front();
        check_eq("rsp_valid", 64'(rsp_valid), 64'(r.id1h));
        check_eq("rsp_rdata", 64'(rsp_rdata), 64'(r.data));
      end else begin
        check_eq("rsp_valid_idle", 64'(rsp_valid), 64'd0);
        check_eq("rsp_rdata_idle", 64'(rsp_rdata), 64'd0);
      end
      xf = req_valid & req_ready;
      if (xf != '0) begin
        idx = 0;
        for (int i = 0; i < NR; i++) if (xf[i]) idx = i;
        c.due   = cyc + 1;
        c.we    = req_we[idx];
        c.addr  = req_addr[idx];
        c.wdata = req_we[idx] ? req_wdata[idx] : '0;
        cmd_sb.push_back(c);
        if (req_we[idx]) begin
          shadow[req_addr[idx]] = req_wdata[idx];
        end else begin
          r.due  = cyc + 2;
          r.id1h = NR'(1) << idx;
          r.data = shadow[req_addr[idx]];
          rsp_sb.push_back(r);
        end
      end
    end
  end

  task automatic expect_ready(input string tag, input logic [NR-1:0] exp);
    @(negedge clk);
    check_eq(tag, 64'(req_ready), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a]    = 32'hC0DE0000 | 32'(a);
      shadow[a] = 32'hC0DE0000 | 32'(a);
    end
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and idle
    repeat (5) begin
      @(negedge clk);
      check_eq("rst_req_ready", 64'(req_ready), 64'd0);
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      check_eq("rst_ram_ctl", 64'({ram_cs, ram_we, ram_oe}), 64'd0);
      check_eq("rst_ram_address", 64'(ram_address), 64'd0);
      check_eq("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    end
    @(posedge clk);
    #1;

    // Burst lock: req 0 writes 0..3 while req 3 waits with a read of 0x02
    for (int k = 0; k < 4; k++) begin
      req_valid    = 4'b1001;
      req_we       = 4'b0001;
      req_lock     = (k < 3) ? 4'b0001 : 4'b0000;
      req_addr[0]  = 8'(k);
      req_wdata[0] = 32'h11110000 + 32'(k);
      req_addr[3]  = 8'h02;
      expect_ready("lock_burst", 4'b0001);
    end
    req_valid = 4'b1000;
    req_we    = '0;
    req_lock  = '0;
    expect_ready("lock_release_grant3", 4'b1000);
    req_valid = '0;
    expect_ready("idle", 4'b0000);

    // Round robin from ptr 0
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) req_addr[i] = 8'h10 + 8'(i);
    for (int k = 0; k < 5; k++) expect_ready("rr_grant", NR'(1) << rr_seq[k]);
    req_valid = '0;
    repeat (2) expect_ready("idle", 4'b0000);

    // Write then read of the same address by different requesters
    req_valid    = 4'b0010;
    req_we       = 4'b0010;
    req_addr[1]  = 8'h20;
    req_wdata[1] = 32'hDEADBEEF;
    expect_ready("raw_write", 4'b0010);
    req_valid    = 4'b0100;
    req_we       = '0;
    req_addr[2]  = 8'h20;
    expect_ready("raw_read", 4'b0100);
    req_valid = '0;
    repeat (3) expect_ready("idle", 4'b0000);

    // Pointer wrap: ptr is 3 here
    req_valid   = 4'b1001;
    req_addr[0] = 8'h30;
    req_addr[3] = 8'h33;
    expect_ready("wrap_first3", 4'b1000);
    expect_ready("wrap_then0", 4'b0001);
    req_valid = '0;
    repeat (2) expect_ready("idle", 4'b0000);

    // Lock held by an idle owner
    req_valid   = 4'b0001;
    req_lock    = 4'b0001;
    req_addr[0] = 8'h05;
    req_addr[1] = 8'h06;
    expect_ready("idle_lock_take", 4'b0001);
    req_valid = 4'b0010;
    repeat (3) expect_ready("idle_owner_stall", 4'b0000);
    req_valid = 4'b0011;
    req_lock  = '0;
    expect_ready("idle_owner_release", 4'b0001);
    req_valid = 4'b0010;
    expect_ready("after_release", 4'b0010);
    req_valid = '0;
    repeat (2) expect_ready("idle", 4'b0000);

    // Reset while a read is in flight
    req_valid   = 4'b0100;
    req_addr[2] = 8'h40;
    expect_ready("pre_reset_read", 4'b0100);
    req_valid = '0;
    rst       = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) expect_ready("post_reset_idle", 4'b0000);

    check_eq("sb_drained", 64'(cmd_sb.size() + rsp_sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
